// File: rtl/dmem_port_ctrl_pkg.sv
// lc3b_types: word and write-mask types shared by the data-memory port.
// Also holds the byte sign-extension helper used on load lanes.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   localparam lc3b_word WORD_MASK = 16'hFFFE;

   function automatic lc3b_word sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/dmem_port_ctrl_byte_lane.sv
// dmem_byte_lane: load lane select/sign-extend and store lane
// replicate/enable for LDB/STB; word accesses pass straight through.
module dmem_byte_lane
   import lc3b_types::*;
(
   input  logic          byte_sel,
   input  logic          store,
   input  logic          lane,
   input  lc3b_word      rdata,
   input  lc3b_word      wdata,
   output lc3b_word      load_data,
   output lc3b_word      store_data,
   output lc3b_mem_wmask wmask
);

   always_comb begin
      load_data  = rdata;
      store_data = wdata;
      wmask      = 2'b11;
      if (byte_sel) begin
         load_data = sext8(lane ? rdata[15:8] : rdata[7:0]);
         if (store) begin
            store_data = {wdata[7:0], wdata[7:0]};
            wmask      = lane ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: MEM-stage data-memory sequencer (LDR/STR, LDB/STB, LDI/STI).
// Optional per-access response timeout enabled by `define DMEM_TIMEOUT_EN.
module dmem_port_ctrl
   import lc3b_types::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          req_read,
   input  logic          req_write,
   input  logic          req_indirect,
   input  logic          req_byte,
   input  lc3b_word      addr,
   input  lc3b_word      wdata,
   input  lc3b_word      dmem_rdata,
   input  logic          dmem_resp,
   output lc3b_word      dmem_addr,
   output logic          dmem_read,
   output logic          dmem_write,
   output lc3b_word      dmem_wdata,
   output lc3b_mem_wmask dmem_byte_enable,
   output lc3b_word      mdr,
   output logic          done,
   output logic          stall,
   output logic          err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IND_RD = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0] state_q, state_d;
   logic       write_q, write_d;
   logic       byte_q, byte_d;
   lc3b_word   addr_q, addr_d;
   lc3b_word   wdata_q, wdata_d;
   lc3b_word   mdr_q, mdr_d;
   logic       err_q, err_d;

   lc3b_word      lane_rdata;
   lc3b_word      lane_wdata;
   lc3b_mem_wmask lane_mask;
   logic          expired;

   dmem_byte_lane u_lane (
      .byte_sel   (byte_q & (state_q == ST_ACCESS)),
      .store      (write_q),
      .lane       (addr_q[0]),
      .rdata      (dmem_rdata),
      .wdata      (wdata_q),
      .load_data  (lane_rdata),
      .store_data (lane_wdata),
      .wmask      (lane_mask)
   );

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if ((state_q == ST_IDLE) || (state_q == ST_DONE) || dmem_resp)
         cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d          = state_q;
      write_d          = write_q;
      byte_d           = byte_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      mdr_d            = mdr_q;
      err_d            = 1'b0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_addr        = '0;
      dmem_wdata       = '0;
      dmem_byte_enable = '0;
      done             = 1'b0;
      stall            = 1'b0;
      err              = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_read | req_write) begin
               stall   = ~reset;
               write_d = req_write;
               byte_d  = req_byte;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = req_indirect ? ST_IND_RD : ST_ACCESS;
            end
         end

         ST_IND_RD: begin
            stall            = 1'b1;
            dmem_read        = 1'b1;
            dmem_addr        = addr_q & WORD_MASK;
            dmem_wdata       = lane_wdata;
            dmem_byte_enable = lane_mask;
            if (dmem_resp) begin
               addr_d  = dmem_rdata;
               state_d = ST_ACCESS;
            end else if (expired) begin
               err_d   = 1'b1;
               mdr_d   = '0;
               state_d = ST_DONE;
            end
         end

         ST_ACCESS: begin
            stall            = 1'b1;
            dmem_read        = ~write_q;
            dmem_write       = write_q;
            dmem_addr        = byte_q ? addr_q : (addr_q & WORD_MASK);
            dmem_wdata       = lane_wdata;
            dmem_byte_enable = lane_mask;
            if (dmem_resp) begin
               if (!write_q) mdr_d = lane_rdata;
               state_d = ST_DONE;
            end else if (expired) begin
               err_d   = 1'b1;
               mdr_d   = '0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign mdr = mdr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
      end
   end

endmodule
